clos_obuf_sync: RTL and testbench

// - Clocked output buffer for one virtual circuit of a buffered SDM-Clos router output port.
// - Sits directly downstream of a central-module (CM) output.
// - Accepts 1-of-4 dual-rail-style tokens (4 data rails per sub-channel plus an eof rail) and

---
 rtl/clos_obuf_sync_if.sv | 27 ++
 rtl/clos_obuf_sync.sv | 158 +++++++++++++++
 tb/tb_clos_obuf_sync.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/clos_obuf_sync_if.sv
// Token-side and sink-side signal bundle of the clos_obuf_sync output buffer.
// slave is the buffer's view; master is the view of the CM plus link driver around it.
interface clos_obuf_sync_if #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
);
   localparam int SCN = DW / 2;
   localparam int AW  = $clog2(DEPTH + 1);

   logic [SCN-1:0] di0, di1, di2, di3;
   logic           di4;
   logic           dia, dia4;
   logic [DW-1:0]  dout;
   logic           deof, dvalid, dready;
   logic [AW-1:0]  count;
   logic           err;

   modport slave (
      input  di0, di1, di2, di3, di4, dready,
      output dia, dia4, dout, deof, dvalid, count, err
   );

   modport master (
      output di0, di1, di2, di3, di4, dready,
      input  dia, dia4, dout, deof, dvalid, count, err
   );
endinterface

// File: rtl/clos_obuf_sync.sv
// Clocked output buffer for one SDM-Clos virtual circuit: 1-of-4 token capture into a DEPTH FIFO.
// Define CLOS_OBUF_ERRCHK_EN to reject and flag multi-hot / eof-with-data tokens.
module clos_obuf_sync #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   clos_obuf_sync_if.slave bus
);
   localparam int SCN = DW / 2;
   localparam int AW  = $clog2(DEPTH + 1);
   localparam int PW  = $clog2(DEPTH);

   typedef enum logic [1:0] {RESYNC, IDLE, HOLD} state_t;

   state_t         state, state_n;
   logic           ack_d, ack_d_n, ack_e, ack_e_n;
   logic [SCN-1:0] any_rail;
   logic [DW-1:0]  dec;
   logic           all_any, no_data, spacer, is_data, is_eof, is_bad;
   logic           push, pop, space;
   logic [DW:0]    mem [DEPTH];
   logic [DW:0]    wdata, head, head_n;
   logic [PW-1:0]  wr_ptr, rd_ptr, rd_n;
   logic [AW-1:0]  count, count_n;
   logic           valid;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Highest-index rail wins inside each sub-channel.
   always_comb begin
      any_rail = '0;
      dec      = '0;
      for (int unsigned k = 0; k < SCN; k++) begin
         any_rail[k] = bus.di0[k] | bus.di1[k] | bus.di2[k] | bus.di3[k];
         if (bus.di3[k])      dec[2*k +: 2] = 2'd3;
         else if (bus.di2[k]) dec[2*k +: 2] = 2'd2;
         else if (bus.di1[k]) dec[2*k +: 2] = 2'd1;
         else                 dec[2*k +: 2] = 2'd0;
      end
   end

   assign all_any = &any_rail;
   assign no_data = ~|any_rail;
   assign spacer  = no_data & ~bus.di4;
   assign is_eof  = bus.di4 & no_data;
   assign wdata   = {is_eof, dec};

`ifdef CLOS_OBUF_ERRCHK_EN
   logic [SCN-1:0] multi;
   logic           err_q;

   always_comb begin
      multi = '0;
      for (int unsigned k = 0; k < SCN; k++) begin
         multi[k] = (bus.di0[k] & bus.di1[k]) | (bus.di0[k] & bus.di2[k]) |
                    (bus.di0[k] & bus.di3[k]) | (bus.di1[k] & bus.di2[k]) |
                    (bus.di1[k] & bus.di3[k]) | (bus.di2[k] & bus.di3[k]);
      end
   end

   assign is_bad  = (all_any & |multi) | (bus.di4 & ~no_data);
   assign is_data = all_any & ~bus.di4 & ~|multi;

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else if (state == IDLE && is_bad) err_q <= 1'b1;
   end
   assign bus.err = err_q;
`else
   assign is_bad  = 1'b0;
   assign is_data = all_any;
   assign bus.err = 1'b0;
`endif

   assign pop   = valid & bus.dready;
   assign space = (count != AW'(DEPTH)) | pop;

   // Illegal tokens are acked without needing FIFO space since they are never stored.
   always_comb begin
      state_n = state;
      ack_d_n = ack_d;
      ack_e_n = ack_e;
      push    = 1'b0;
      unique case (state)
         RESYNC: if (spacer) state_n = IDLE;
         IDLE: begin
            if (is_bad) begin
               state_n = HOLD;
               ack_d_n = 1'b1;
               ack_e_n = bus.di4;
            end else if ((is_data | is_eof) && space) begin
               push    = 1'b1;
               state_n = HOLD;
               ack_d_n = is_data;
               ack_e_n = is_eof;
            end
         end
         HOLD: begin
            if (spacer) begin
               state_n = IDLE;
               ack_d_n = 1'b0;
               ack_e_n = 1'b0;
            end
         end
         default: state_n = RESYNC;
      endcase
   end

   // Registered head: bypass the write data when the written slot becomes the head.
   always_comb begin
      rd_n    = pop ? nxt(rd_ptr) : rd_ptr;
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + AW'(1);
         2'b01:   count_n = count - AW'(1);
         default: count_n = count;
      endcase
      head_n = '0;
      if (count_n != '0) head_n = (push && wr_ptr == rd_n) ? wdata : mem[rd_n];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RESYNC;
         ack_d  <= 1'b0;
         ack_e  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
         valid  <= 1'b0;
      end else begin
         state  <= state_n;
         ack_d  <= ack_d_n;
         ack_e  <= ack_e_n;
         if (push) wr_ptr <= nxt(wr_ptr);
         rd_ptr <= rd_n;
         count  <= count_n;
         head   <= head_n;
         valid  <= (count_n != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign bus.dia    = ack_d;
   assign bus.dia4   = ack_e;
   assign bus.dout   = head[DW-1:0];
   assign bus.deof   = head[DW];
   assign bus.dvalid = valid;
   assign bus.count  = count;
endmodule

// File: tb/tb_clos_obuf_sync.sv
// Randomized bench for clos_obuf_sync: a queue-based model of token capture, acks and FIFO order.
// Honours CLOS_OBUF_ERRCHK_EN the same way the design does.
module tb_clos_obuf_sync;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int SCN   = DW / 2;
   localparam int K_SPC = 0, K_PART = 1, K_DATA = 2, K_EOF = 3, K_MULTI = 4;
`ifdef CLOS_OBUF_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   logic clk, rst;
   int   checks, failures, rdy_mode;
   int   drv_kind;
   logic [DW-1:0] drv_val;

   logic [DW:0] q [$];
   bit m_dia, m_dia4, m_hold, m_resync, m_err, m_clean;

   clos_obuf_sync_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
   clos_obuf_sync #(.DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input int kind, input logic [DW-1:0] val);
      logic [SCN-1:0] r [4];
      logic [SCN-1:0] mask;
      int unsigned sel;
      for (int j = 0; j < 4; j++) r[j] = '0;
      bus.di4 = 1'b0;
      mask = '1;
      if (kind == K_PART) mask = SCN'($urandom_range(1, (1 << SCN) - 2));
      if (kind == K_DATA || kind == K_PART || kind == K_MULTI) begin
         for (int k = 0; k < SCN; k++) begin
            if (mask[k]) begin
               sel = val[2*k +: 2];
               r[sel][k] = 1'b1;
               if (kind == K_MULTI)
                  for (int j = 0; j < 4; j++)
                     if (j < sel && ((k == 0 && j == 0) || $urandom_range(0, 1) == 1)) r[j][k] = 1'b1;
            end
         end
      end
      if (kind == K_EOF) bus.di4 = 1'b1;
      bus.di0 = r[0];
      bus.di1 = r[1];
      bus.di2 = r[2];
      bus.di3 = r[3];
      drv_kind = kind;
      drv_val  = val;
   endtask

   // Effect of one clock edge, from the currently driven token class and dready.
   task automatic model_edge(input bit rdy);
      bit pop, space, cap;
      if (rst) begin
         q.delete();
         m_dia = 0; m_dia4 = 0; m_hold = 0; m_resync = 1; m_err = 0; m_clean = 1;
         return;
      end
      pop   = rdy && q.size() != 0;
      space = q.size() < DEPTH || pop;
      cap   = 0;
      if (m_resync) m_resync = (drv_kind != K_SPC);
      else if (m_hold) begin
         if (drv_kind == K_SPC) begin m_hold = 0; m_dia = 0; m_dia4 = 0; end
      end else if (drv_kind == K_MULTI && ERRCHK) begin
         m_hold = 1; m_dia = 1; m_err = 1;
      end else if (drv_kind inside {K_DATA, K_EOF, K_MULTI} && space) begin
         cap = 1; m_hold = 1;
         m_dia  = (drv_kind != K_EOF);
         m_dia4 = (drv_kind == K_EOF);
      end
      if (pop) void'(q.pop_front());
      if (cap) begin
         q.push_back(drv_kind == K_EOF ? {1'b1, {DW{1'b0}}} : {1'b0, drv_val});
         m_clean = 0;
      end
   endtask

   task automatic cycle();
      bit rdy;
      rdy = (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : (rdy_mode == 1);
      bus.dready = rdy;
      model_edge(rdy);
      @(posedge clk);
      @(negedge clk);
      chk("dia", bus.dia, m_dia);
      chk("dia4", bus.dia4, m_dia4);
      chk("dvalid", bus.dvalid, q.size() != 0);
      chk("count", bus.count, q.size());
      chk("err", bus.err, m_err);
      if (q.size() != 0) begin
         chk("dout", bus.dout, q[0][DW-1:0]);
         chk("deof", bus.deof, q[0][DW]);
      end else if (m_clean) begin
         chk("dout_rst", bus.dout, 0);
         chk("deof_rst", bus.deof, 0);
      end
   endtask

   task automatic send(input int kind, input logic [DW-1:0] val, input bit part);
      int n;
      if (part) begin drive(K_PART, val); cycle(); end
      drive(kind, val);
      n = 0;
      do begin cycle(); n++; end while (!(m_dia || m_dia4) && n < 200);
      if (n >= 200) chk("ack_timeout", bus.dia | bus.dia4, 1);
      drive(K_SPC, '0);
      n = 0;
      do begin cycle(); n++; end while ((m_dia || m_dia4) && n < 200);
   endtask

   task automatic drain();
      int n, saved;
      saved = rdy_mode;
      rdy_mode = 1;
      n = 0;
      while (q.size() != 0 && n < 100) begin cycle(); n++; end
      rdy_mode = saved;
   endtask

   function automatic logic [DW-1:0] rnd_val(input bit multi);
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (multi) v[1:0] = 2'($urandom_range(1, 3));
      return v;
   endfunction

   initial begin
      int n, p;
      logic [DW-1:0] v;
      checks = 0; failures = 0; rdy_mode = 0;
      rst = 1'b1;
      bus.dready = 1'b0;
      drive(K_DATA, 8'hE4);
      @(negedge clk);

      // Token held across reset must not be captured until a spacer is seen.
      cycle(); cycle();
      rst = 1'b0;
      repeat (3) cycle();
      drive(K_SPC, '0);
      cycle();
      send(K_DATA, 8'hE4, 0);
      chk("first_dout", bus.dout, 8'hE4);

      // Fill to DEPTH with no pops, then a 5th token is taken only on a pop edge.
      drain();
      rdy_mode = 0;
      repeat (DEPTH) send(K_DATA, rnd_val(0), 0);
      chk("fill_cnt", bus.count, DEPTH);
      drive(K_DATA, rnd_val(0));
      repeat (3) cycle();
      rdy_mode = 1;
      cycle();
      rdy_mode = 0;
      chk("fifth_cnt", bus.count, DEPTH);
      chk("fifth_ack", bus.dia, 1);
      drive(K_SPC, '0);
      cycle();

      // eof token at an empty head.
      drain();
      send(K_EOF, '0, 0);
      chk("eof_head", bus.deof, 1);
      chk("eof_dout", bus.dout, 0);

      // Back-to-back tokens with continuous pop.
      drain();
      rdy_mode = 1;
      repeat (12) send(K_DATA, rnd_val(0), 0);

      // Reset while holding an ack with three entries queued.
      drain();
      rdy_mode = 0;
      send(K_DATA, rnd_val(0), 0);
      send(K_DATA, rnd_val(0), 0);
      drive(K_DATA, rnd_val(0));
      n = 0;
      do begin cycle(); n++; end while (!m_dia && n < 50);
      chk("hold_cnt", bus.count, 3);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_cnt", bus.count, 0);
      chk("rst_valid", bus.dvalid, 0);
      chk("rst_dia", bus.dia, 0);
      repeat (3) cycle();
      drive(K_SPC, '0);
      cycle();

      // Sub-channel 0 with rails 0 and 2 high.
      v = rnd_val(0);
      v[1:0] = 2'd2;
      send(K_MULTI, v, 0);
      chk("multi_err", bus.err, ERRCHK);
      chk("multi_cnt", bus.count, ERRCHK ? 0 : 1);

      // Random traffic with random back-pressure.
      rdy_mode = 2;
      repeat (300) begin
         p = $urandom_range(0, 9);
         if (p == 0)      send(K_EOF, '0, $urandom_range(0, 3) == 0);
         else if (p == 1) send(K_MULTI, rnd_val(1), 0);
         else             send(K_DATA, rnd_val(0), $urandom_range(0, 3) == 0);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
